// File: rtl/mips_mc_if.sv
// Control boundary of the multicycle MIPS datapath: IR fields and flags in, datapath enables out.
// master = control FSM, slave = datapath side.
interface mips_mc_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic             iord;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_src;
  logic [2:0]       alu_control;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic             illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_control, state, instr_count, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_control, state, instr_count, illegal
  );
endinterface

// File: rtl/mips_mc_control.sv
// Moore control FSM for the multicycle MIPS datapath with memory wait states and a fetch counter.
// Optional MC_BNE_EN adds bne (shares the BRANCH state with beq).
module mips_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  mips_mc_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           state_q;
  state_t           state_d;
  ctl_t             ctl_q;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q;
  logic             br_take;

  function automatic logic funct_ok(input logic [5:0] fn);
    return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
           (fn == 6'b100101) || (fn == 6'b101010);
  endfunction

  function automatic logic [2:0] alu_op(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      6'b100010: op = ALU_SUB;
      6'b100100: op = ALU_AND;
      6'b100101: op = ALU_OR;
      6'b101010: op = ALU_SLT;
      default:   op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn, input logic mr);
    state_t n;
    case (s)
      FETCH:   n = mr ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: n = MEMADR;
          OP_RTYPE:     n = funct_ok(fn) ? EXECUTE : HALT;
          OP_BEQ:       n = BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       n = BRANCH;
`endif
          OP_ADDI:      n = ADDIEX;
          OP_J:         n = JUMP;
          default:      n = HALT;
        endcase
      end
      MEMADR:  n = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   n = mr ? MEMWB : MEMRD;
      MEMWR:   n = mr ? FETCH : MEMWR;
      EXECUTE: n = ALUWB;
      ADDIEX:  n = ADDIWB;
      HALT:    n = HALT;
      default: n = FETCH;  // write-back states, BRANCH, JUMP and the unused codes 13..15
    endcase
    return n;
  endfunction

  function automatic ctl_t moore_ctl(input state_t s, input logic [5:0] fn);
    ctl_t c;
    c             = '0;
    c.alu_control = ALU_ADD;
    case (s)
      FETCH:   c.alu_src_b = 2'b01;
      DECODE:  c.alu_src_b = 2'b11;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECUTE: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = alu_op(fn);
      end
      ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = ALU_SUB;
        c.pc_src      = 2'b01;
      end
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDIWB:  c.reg_write = 1'b1;
      JUMP:    c.pc_src = 2'b10;
      default: c.alu_src_b = 2'b00;
    endcase
    return c;
  endfunction

  assign state_d = next_state(state_q, bus.opcode, bus.funct, bus.mem_ready);

  // Outputs are decoded from the next state so they are registered yet line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      ctl_q     <= moore_ctl(FETCH, 6'b000000);
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= moore_ctl(state_d, bus.funct);
      illegal_q <= illegal_q | (state_d == HALT);
      if (state_q == FETCH && bus.mem_ready) begin
        count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef MC_BNE_EN
  assign br_take = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
  assign br_take = bus.zero;
`endif

  // mem_ready and zero act combinationally; reset masks them so the reset decode is FETCH idle.
  assign bus.ir_write = ~reset & (state_q == FETCH) & bus.mem_ready;
  assign bus.pc_en    = ~reset & (((state_q == FETCH) & bus.mem_ready) |
                                  (state_q == JUMP) |
                                  ((state_q == BRANCH) & br_take));

  assign bus.iord        = ctl_q.iord;
  assign bus.mem_write   = ctl_q.mem_write;
  assign bus.reg_dst     = ctl_q.reg_dst;
  assign bus.mem_to_reg  = ctl_q.mem_to_reg;
  assign bus.reg_write   = ctl_q.reg_write;
  assign bus.alu_src_a   = ctl_q.alu_src_a;
  assign bus.alu_src_b   = ctl_q.alu_src_b;
  assign bus.pc_src      = ctl_q.pc_src;
  assign bus.alu_control = ctl_q.alu_control;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Moore-style control FSM for the multicycle MIPS datapath; replaces the single-cycle combinational control unit.
- Decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the shared-memory, register-file and PC enables.
- Supports handshaked memory wait states and keeps a retired-instruction counter for the bench.

Parameters:
- CNT_W, 32, width of the instr_count fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_en  out  1  PC write enable.
- iord  out  1  0 = memory address from PC, 1 = from ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = data register.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- state  out  4  current state encoding (debug).
- instr_count  out  CNT_W  instructions fetched since reset.
- illegal  out  1  sticky illegal-instruction flag.

Behaviour:
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12.
- 13–15 unused; any unused state goes to FETCH on the next edge.

Reset:
- Asynchronous; effective immediately, including mid-instruction or mid-memory-wait.
- state=FETCH, instr_count=0, illegal=0.
- Outputs take the FETCH decode with mem_ready=0: all enables 0, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, alu_control=010.

Output rules:
- Every output not listed for a state is 0; alu_control defaults to 010.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, add. ir_write and pc_en=1 only while mem_ready=1; otherwise hold in FETCH. With mem_ready=1 go to DECODE and instr_count += 1 (wraps modulo 2^CNT_W).
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXECUTE if funct is one of 100000, 100010, 100100, 100101, 101010; otherwise HALT.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JUMP.
  - Any other opcode -> HALT.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEMWR: iord=1, mem_write=1 held every cycle until mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00. alu_control from funct: add 010, sub 110, and 000, or 001, slt 111. Then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01. pc_en=zero (combinational from zero). Then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add, then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- JUMP: pc_src=10, pc_en=1, then FETCH.
- HALT: all enables 0, illegal=1, stays in HALT until reset. Entering HALT sets illegal on the same edge.

Latency per instruction, counting FETCH as 1 cycle with zero wait states:
- lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds 1.

Other rules:
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- mem_write and reg_write are never 1 in the same cycle.
- ir_write is only ever 1 in FETCH.

Optional Feature:
- Macro MC_BNE_EN.
- Defined: opcode 000101 (bne) in DECODE -> BRANCH. In BRANCH, pc_en = zero for beq and pc_en = ~zero for bne. Opcode is sampled from the still-valid instruction register.
- Undefined: 000101 is illegal -> HALT.

Test Plan:
- Reset with mem_ready=1, release, opcode=000000 funct=100000 -> states 0,1,6,7,0; reg_write=1 in the ALUWB cycle with reg_dst=1; instr_count=2 after the second FETCH.
- lw (100011) with mem_ready held 0 for 3 cycles in MEMRD -> MEMRD lasts 4 cycles, iord=1 throughout, then MEMWB with reg_write=1 and mem_to_reg=1; total 8 cycles.
- sw (101011) with mem_ready=0 for 2 cycles -> mem_write=1 for exactly 3 cycles, reg_write never 1.
- beq with zero=1 -> pc_en=1 and pc_src=01 in BRANCH. Repeat with zero=0 -> pc_en=0.
- opcode=111111 -> HALT, illegal=1, no enables; hold 10 cycles; assert reset -> state=0, illegal=0 asynchronously before the next edge.
- Assert reset mid-MEMWR -> mem_write drops immediately, instr_count=0. bne (000101) -> BRANCH with pc_en=~zero if MC_BNE_EN is defined, otherwise HALT.
